alu_pipe_m: RTL and testbench

ALU_PIPE_M -- requirements
Module: alu_pipe_m

---
 rtl/alu_pipe_m_if.sv | 35 +++
 rtl/alu_pipe_m.sv | 122 ++++++++++++
 tb/tb_alu_pipe_m.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_m_if.sv
// Opcode package and valid/ready command/result bundle
// shared by alu_pipe_m and its users.
package ex_type_pkg;
    typedef enum logic [2:0] {
        HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
    } opcode_e;
endpackage

interface alu_pipe_m_if #(
    parameter int WIDTH = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    ex_type_pkg::opcode_e  opcode;
    logic [WIDTH-1:0]      data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      alu_out;
    logic                  zero;
    logic                  carry;
    logic [WIDTH-1:0]      accum;
    logic                  halted;

    modport master (
        output in_valid, opcode, data, out_ready,
        input  in_ready, out_valid, alu_out,
        input  zero, carry, accum, halted
    );

    modport slave (
        input  in_valid, opcode, data, out_ready,
        output in_ready, out_valid, alu_out,
        output zero, carry, accum, halted
    );
endinterface

// File: rtl/alu_pipe_m.sv
// Two-stage accumulator ALU: S1 latches the command,
// S2 computes against accum and holds the result.
module alu_pipe_m #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_,
    alu_pipe_m_if.slave bus
);
    import ex_type_pkg::*;

    logic             s1_valid_q, s1_valid_d;
    opcode_e          s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] accum_q, accum_d;
    logic             halted_q, halted_d;

    logic             s2_take;
    logic             in_take;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_wr;

    assign s2_take = s1_valid_q
                   && (!out_valid_q || bus.out_ready);

    // Gated by rst_ so in_ready reads low throughout reset.
    assign bus.in_ready = rst_ && !halted_q
                        && (!s1_valid_q || s2_take);

    assign in_take = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_q;
    assign bus.zero      = (alu_q == '0);
    assign bus.carry     = carry_q;
    assign bus.accum     = accum_q;
    assign bus.halted    = halted_q;

    always_comb begin
        sum    = {1'b0, accum_q} + {1'b0, s1_data_q};
        res    = accum_q;
        res_c  = 1'b0;
        res_wr = 1'b0;
        unique case (1'b1)
            (s1_op_q == ADD): begin
                res    = sum[WIDTH-1:0];
                res_c  = sum[WIDTH];
                res_wr = 1'b1;
            end
            (s1_op_q == AND): begin
                res    = accum_q & s1_data_q;
                res_wr = 1'b1;
            end
            (s1_op_q == XOR): begin
                res    = accum_q ^ s1_data_q;
                res_wr = 1'b1;
            end
            (s1_op_q == LDA): begin
                res    = s1_data_q;
                res_wr = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        alu_d       = alu_q;
        carry_d     = carry_q;
        accum_d     = accum_q;
        halted_d    = halted_q;

        if (in_take) begin
            s1_valid_d = 1'b1;
            s1_op_d    = bus.opcode;
            s1_data_d  = bus.data;
        end else if (s2_take) begin
            s1_valid_d = 1'b0;
        end

        if (s2_take) begin
            out_valid_d = 1'b1;
            alu_d       = res;
            carry_d     = res_c;
            if (res_wr) accum_d = res;
            if (s1_op_q == HLT) halted_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= HLT;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            alu_q       <= '0;
            carry_q     <= 1'b0;
            accum_q     <= '0;
            halted_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            alu_q       <= alu_d;
            carry_q     <= carry_d;
            accum_q     <= accum_d;
            halted_q    <= halted_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe_m.sv
// Directed bench for alu_pipe_m: an 8-bit instance for
// the main scenarios and a 16-bit instance for wrap/carry.
module tb_alu_pipe_m;
    import ex_type_pkg::*;

    logic clk = 1'b0;
    logic rst_;
    int   checks   = 0;
    int   failures = 0;

    alu_pipe_m_if #(.WIDTH(8))  bus8  ();
    alu_pipe_m_if #(.WIDTH(16)) bus16 ();

    alu_pipe_m #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus8.slave)
    );

    alu_pipe_m #(.WIDTH(16)) dut16 (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus16.slave)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_ = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.opcode    = HLT;
        bus8.data      = '0;
        bus8.out_ready = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.opcode    = HLT;
        bus16.data      = '0;
        bus16.out_ready = 1'b0;
        #1 rst_ = 1'b0;
        #2;
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b exp=0", bus8.out_valid);
        end
        checks++;
        if (bus8.alu_out !== 8'h00) begin
            failures++;
            $display("FAIL rst_alu_out got=%h exp=00", bus8.alu_out);
        end
        checks++;
        if (bus8.zero !== 1'b1) begin
            failures++;
            $display("FAIL rst_zero got=%b exp=1", bus8.zero);
        end
        checks++;
        if (bus8.carry !== 1'b0) begin
            failures++;
            $display("FAIL rst_carry got=%b exp=0", bus8.carry);
        end
        checks++;
        if (bus8.accum !== 8'h00) begin
            failures++;
            $display("FAIL rst_accum got=%h exp=00", bus8.accum);
        end
        checks++;
        if (bus8.halted !== 1'b0) begin
            failures++;
            $display("FAIL rst_halted got=%b exp=0", bus8.halted);
        end
        checks++;
        if (bus8.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready got=%b exp=0", bus8.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rel_in_ready got=%b exp=1", bus8.in_ready);
        end
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rel_out_valid got=%b exp=0", bus8.out_valid);
        end
    endtask

    task automatic test_stream();
        opcode_e    ops [4] = '{LDA, ADD, AND, XOR};
        logic [7:0] dat [4] = '{8'hDA, 8'h37, 8'h37, 8'h11};
        logic [7:0] ea  [4] = '{8'hDA, 8'h11, 8'h11, 8'h00};
        logic       ec  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       ez  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 2 || i == 6) begin
                checks++;
                if (bus8.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_idle[%0d] out_valid=%b exp=0",
                             i, bus8.out_valid);
                end
            end else begin
                checks++;
                if (bus8.out_valid !== 1'b1
                    || bus8.alu_out !== ea[i-2]) begin
                    failures++;
                    $display("FAIL stream_res[%0d] v=%b alu=%h exp v=1 alu=%h",
                             i - 2, bus8.out_valid, bus8.alu_out, ea[i-2]);
                end
                checks++;
                if (bus8.carry !== ec[i-2] || bus8.zero !== ez[i-2]) begin
                    failures++;
                    $display("FAIL stream_flags[%0d] c=%b z=%b exp c=%b z=%b",
                             i - 2, bus8.carry, bus8.zero, ec[i-2], ez[i-2]);
                end
                checks++;
                if (bus8.accum !== ea[i-2]) begin
                    failures++;
                    $display("FAIL stream_accum[%0d] got=%h exp=%h",
                             i - 2, bus8.accum, ea[i-2]);
                end
            end
            if (i < 4) begin
                bus8.in_valid = 1'b1;
                bus8.opcode   = ops[i];
                bus8.data     = dat[i];
                #1;
                checks++;
                if (bus8.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_in_ready[%0d] got=%b exp=1",
                             i, bus8.in_ready);
                end
            end else begin
                bus8.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_nonwrite();
        opcode_e    ops [4] = '{LDA, STO, SKZ, JMP};
        logic [7:0] dat [4] = '{8'h12, 8'h00, 8'hFF, 8'h55};
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (bus8.out_valid !== 1'b1 || bus8.alu_out !== 8'h12
                    || bus8.carry !== 1'b0 || bus8.zero !== 1'b0) begin
                    failures++;
                    $display("FAIL nonwrite_res[%0d] v=%b alu=%h c=%b z=%b exp v=1 alu=12 c=0 z=0",
                             i - 2, bus8.out_valid, bus8.alu_out,
                             bus8.carry, bus8.zero);
                end
                checks++;
                if (bus8.accum !== 8'h12) begin
                    failures++;
                    $display("FAIL nonwrite_accum[%0d] got=%h exp=12",
                             i - 2, bus8.accum);
                end
            end
            bus8.in_valid = (i < 4);
            bus8.opcode   = ops[i % 4];
            bus8.data     = dat[i % 4];
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        opcode_e    ops [4] = '{LDA, ADD, XOR, AND};
        logic [7:0] dat [4] = '{8'h05, 8'h03, 8'h0F, 8'h0C};
        logic [7:0] ea  [4] = '{8'h05, 8'h08, 8'h07, 8'h04};
        logic       rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b1};
        int         tx = 0;
        int         rx = 0;
        logic       stall = 1'b0;
        logic       held = 1'b0;
        logic [7:0] held_a = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (held) begin
                checks++;
                if (bus8.out_valid !== 1'b1 || bus8.alu_out !== held_a) begin
                    failures++;
                    $display("FAIL bp_hold[%0d] v=%b alu=%h exp v=1 alu=%h",
                             c, bus8.out_valid, bus8.alu_out, held_a);
                end
            end
            bus8.in_valid  = (tx < 4);
            bus8.opcode    = ops[tx % 4];
            bus8.data      = dat[tx % 4];
            bus8.out_ready = (c < 8) ? rdy[c] : 1'b1;
            #1;
            if (bus8.in_valid && !bus8.in_ready) stall = 1'b1;
            if (bus8.in_valid && bus8.in_ready) tx++;
            if (bus8.out_valid && bus8.out_ready) begin
                checks++;
                if (rx >= 4 || bus8.alu_out !== ea[rx % 4]) begin
                    failures++;
                    $display("FAIL bp_result[%0d] alu=%h exp=%h",
                             rx, bus8.alu_out, ea[rx % 4]);
                end
                rx++;
            end
            held   = bus8.out_valid && !bus8.out_ready;
            held_a = bus8.alu_out;
        end
        checks++;
        if (tx != 4 || rx != 4) begin
            failures++;
            $display("FAIL bp_counts sent=%0d got=%0d exp 4/4", tx, rx);
        end
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL bp_in_ready_drop got=%b exp=1", stall);
        end
        checks++;
        if (bus8.accum !== 8'h04 || bus8.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_end accum=%h v=%b exp accum=04 v=0",
                     bus8.accum, bus8.out_valid);
        end
    endtask

    task automatic test_halt();
        logic [7:0] ea [2] = '{8'h04, 8'h05};
        int tx = 0;
        int rx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus8.in_valid  = 1'b1;
            bus8.opcode    = (tx == 0) ? HLT : (tx == 1) ? ADD : LDA;
            bus8.data      = (tx == 1) ? 8'h01 : 8'hAA;
            bus8.out_ready = 1'b1;
            #1;
            if (bus8.in_valid && bus8.in_ready) tx++;
            if (bus8.out_valid && bus8.out_ready) begin
                checks++;
                if (rx >= 2 || bus8.alu_out !== ea[rx % 2]) begin
                    failures++;
                    $display("FAIL halt_result[%0d] alu=%h exp=%h",
                             rx, bus8.alu_out, ea[rx % 2]);
                end
                rx++;
            end
        end
        checks++;
        if (tx != 2 || rx != 2) begin
            failures++;
            $display("FAIL halt_counts accepted=%0d retired=%0d exp 2/2", tx, rx);
        end
        checks++;
        if (bus8.halted !== 1'b1 || bus8.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_state halted=%b in_ready=%b exp 1/0",
                     bus8.halted, bus8.in_ready);
        end
        checks++;
        if (bus8.accum !== 8'h05) begin
            failures++;
            $display("FAIL halt_accum got=%h exp=05", bus8.accum);
        end
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #1 rst_ = 1'b0;
        #1 rst_ = 1'b1;
        #1;
        checks++;
        if (bus8.halted !== 1'b0 || bus8.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_clear halted=%b in_ready=%b exp 0/1",
                     bus8.halted, bus8.in_ready);
        end
        @(negedge clk);
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.opcode    = LDA;
        bus8.data      = 8'h33;
        @(negedge clk);
        bus8.opcode = ADD;
        bus8.data   = 8'h01;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.alu_out !== 8'h33) begin
            failures++;
            $display("FAIL rmid_full v=%b alu=%h exp v=1 alu=33",
                     bus8.out_valid, bus8.alu_out);
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.alu_out !== 8'h00
            || bus8.zero !== 1'b1 || bus8.carry !== 1'b0) begin
            failures++;
            $display("FAIL rmid_out v=%b alu=%h z=%b c=%b exp v=0 alu=00 z=1 c=0",
                     bus8.out_valid, bus8.alu_out, bus8.zero, bus8.carry);
        end
        checks++;
        if (bus8.accum !== 8'h00 || bus8.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_state accum=%h in_ready=%b exp 00/0",
                     bus8.accum, bus8.in_ready);
        end
        @(negedge clk);
        rst_ = 1'b1;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus8.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rmid_ghost[%0d] out_valid=%b exp=0",
                         i, bus8.out_valid);
            end
        end
        bus8.in_valid = 1'b1;
        bus8.opcode   = LDA;
        bus8.data     = 8'h7E;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_in_ready got=%b exp=1", bus8.in_ready);
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_latency out_valid=%b exp=0", bus8.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.alu_out !== 8'h7E
            || bus8.accum !== 8'h7E) begin
            failures++;
            $display("FAIL rmid_new v=%b alu=%h accum=%h exp v=1 alu=7e accum=7e",
                     bus8.out_valid, bus8.alu_out, bus8.accum);
        end
    endtask

    task automatic test_width16();
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b1;
        bus16.opcode   = LDA;
        bus16.data     = 16'hFFFF;
        @(negedge clk);
        bus16.opcode = ADD;
        bus16.data   = 16'h0001;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        checks++;
        if (bus16.out_valid !== 1'b1 || bus16.alu_out !== 16'hFFFF
            || bus16.carry !== 1'b0) begin
            failures++;
            $display("FAIL w16_lda v=%b alu=%h c=%b exp v=1 alu=ffff c=0",
                     bus16.out_valid, bus16.alu_out, bus16.carry);
        end
        @(negedge clk);
        checks++;
        if (bus16.out_valid !== 1'b1 || bus16.alu_out !== 16'h0000) begin
            failures++;
            $display("FAIL w16_add v=%b alu=%h exp v=1 alu=0000",
                     bus16.out_valid, bus16.alu_out);
        end
        checks++;
        if (bus16.carry !== 1'b1 || bus16.zero !== 1'b1
            || bus16.accum !== 16'h0000) begin
            failures++;
            $display("FAIL w16_flags c=%b z=%b accum=%h exp c=1 z=1 accum=0000",
                     bus16.carry, bus16.zero, bus16.accum);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_nonwrite();
        test_backpressure();
        test_halt();
        test_reset_mid();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
